// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO peripheral: default sizes and register offsets.
package gpio_pkg;

    localparam int GPIO_WIDTH = 8;
    localparam int GPIO_DEB_W = 16;

    // Word index of each register, taken from addr[4:2].
    typedef enum logic [2:0] {
        REG_DOUT = 3'd0,
        REG_DIR  = 3'd1,
        REG_DIN  = 3'd2,
        REG_RISE = 3'd3,
        REG_FALL = 3'd4,
        REG_PEND = 3'd5,
        REG_DEB  = 3'd6,
        REG_RSVD = 3'd7
    } gpio_reg_e;

    // Byte offset of a register within the peripheral window.
    function automatic logic [4:0] reg_offset(input gpio_reg_e r);
        return {r, 2'b00};
    endfunction

endpackage

// File: rtl/peripheral_gpio_if.sv
// SOC-side bus of the GPIO peripheral: strobes, address, write data and read data.
interface peripheral_gpio_if;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] d_in;
    logic [31:0] d_out;

    modport master (output cs, rd, wr, addr, d_in, input d_out);
    modport slave  (input cs, rd, wr, addr, d_in, output d_out);
endinterface

// File: rtl/gpio_debounce.sv
// Input conditioning: two-flop synchroniser followed by a tick-based debouncer.
// With deb_n = 0 the debouncer is bypassed and follows the synchroniser.
module gpio_debounce #(
    parameter int WIDTH = 8,
    parameter int DEB_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin_in,
    input  logic [DEB_W-1:0] deb_n,
    input  logic             deb_wr,
    output logic [WIDTH-1:0] deb_out
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] sample;
    logic [WIDTH-1:0] stable;
    logic [DEB_W-1:0] prescaler;
    logic             bypass;
    logic             tick;

    assign bypass = (deb_n == '0);
    // A write to the period register restarts the prescaler, so no tick that cycle.
    assign tick   = !bypass && !deb_wr && (prescaler == deb_n - DEB_W'(1));
    assign stable = ~(sync2 ^ sample);

    // Two-flop synchroniser on the asynchronous pad inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pin_in;
            sync2 <= sync1;
        end
    end

    // Prescaler counting 0..deb_n-1; held at 0 in bypass and cleared on a period write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
        end else if (deb_wr || bypass || tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + DEB_W'(1);
        end
    end

    // Per-pin update only when the pin agreed on two consecutive ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample  <= '0;
            deb_out <= '0;
        end else if (bypass) begin
            sample  <= sync2;
            deb_out <= sync2;
        end else if (tick) begin
            sample  <= sync2;
            deb_out <= (sync2 & stable) | (deb_out & ~stable);
        end
    end

endmodule

// File: rtl/peripheral_gpio.sv
// Memory-mapped GPIO peripheral: register file, edge detection, sticky
// write-1-to-clear pending flags with a level interrupt, and registered read data.
module peripheral_gpio
    import gpio_pkg::*;
#(
    parameter int WIDTH = GPIO_WIDTH,
    parameter int DEB_W = GPIO_DEB_W
) (
    input  logic               clk,
    input  logic               reset,
    peripheral_gpio_if.slave   bus,
    input  logic [WIDTH-1:0]   gpio_in,
    output logic [WIDTH-1:0]   gpio_out,
    output logic [WIDTH-1:0]   gpio_oe,
    output logic               irq
);

    logic [WIDTH-1:0] dout_r;
    logic [WIDTH-1:0] dir_r;
    logic [WIDTH-1:0] rise_en_r;
    logic [WIDTH-1:0] fall_en_r;
    logic [WIDTH-1:0] pend_r;
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] deb_val;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] pend_next;
    logic [DEB_W-1:0] deb_r;
    logic [31:0]      rdata;
    logic [31:0]      d_out_r;
    logic             wr_en;
    logic             rd_en;
    logic             deb_wr;
    gpio_reg_e        sel;
    logic             unused_bus;

    assign wr_en  = bus.cs & bus.wr;
    assign rd_en  = bus.cs & bus.rd;
    assign sel    = gpio_reg_e'(bus.addr[4:2]);
    assign deb_wr = wr_en && (sel == REG_DEB);

    // Byte-lane bits and data bits beyond the register widths carry no meaning here.
    assign unused_bus = ^{bus.addr[1:0], bus.d_in};

    assign gpio_out  = dout_r;
    assign gpio_oe   = dir_r;
    assign bus.d_out = d_out_r;

    gpio_debounce #(
        .WIDTH (WIDTH),
        .DEB_W (DEB_W)
    ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .pin_in  (gpio_in),
        .deb_n   (deb_r),
        .deb_wr  (deb_wr),
        .deb_out (deb_val)
    );

    // Writable configuration registers; DATA_IN, PENDING and the reserved slot are not stored here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_r    <= '0;
            dir_r     <= '0;
            rise_en_r <= '0;
            fall_en_r <= '0;
            deb_r     <= '0;
        end else if (wr_en) begin
            case (sel)
                REG_DOUT: dout_r    <= bus.d_in[WIDTH-1:0];
                REG_DIR:  dir_r     <= bus.d_in[WIDTH-1:0];
                REG_RISE: rise_en_r <= bus.d_in[WIDTH-1:0];
                REG_FALL: fall_en_r <= bus.d_in[WIDTH-1:0];
                REG_DEB:  deb_r     <= bus.d_in[DEB_W-1:0];
                default:  ;
            endcase
        end
    end

    // Edge detection and pending update; a new edge beats a clear on the same bit.
    always_comb begin
        rise      = deb_val & ~prev_r;
        fall      = ~deb_val & prev_r;
        clr       = '0;
        if (wr_en && (sel == REG_PEND)) begin
            clr = bus.d_in[WIDTH-1:0];
        end
        pend_next = (pend_r & ~clr) | (rise & rise_en_r) | (fall & fall_en_r);
    end

    // Previous debounced value, sticky pending flags and the registered interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_r <= '0;
            pend_r <= '0;
            irq    <= 1'b0;
        end else begin
            prev_r <= deb_val;
            pend_r <= pend_next;
            irq    <= |pend_next;
        end
    end

    // Read mux over the current (pre-write) register contents, zero-extended.
    always_comb begin
        rdata = '0;
        case (sel)
            REG_DOUT: rdata[WIDTH-1:0] = dout_r;
            REG_DIR:  rdata[WIDTH-1:0] = dir_r;
            REG_DIN:  rdata[WIDTH-1:0] = deb_val;
            REG_RISE: rdata[WIDTH-1:0] = rise_en_r;
            REG_FALL: rdata[WIDTH-1:0] = fall_en_r;
            REG_PEND: rdata[WIDTH-1:0] = pend_r;
            REG_DEB:  rdata[DEB_W-1:0] = deb_r;
            default:  rdata = '0;
        endcase
    end

    // Read data register: loads on a read strobe and holds until the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_out_r <= '0;
        end else if (rd_en) begin
            d_out_r <= rdata;
        end
    end

endmodule

// File: tb/tb_peripheral_gpio.sv
// Self-checking bench for peripheral_gpio: expected read data is queued when a
// read strobe is driven and compared when d_out becomes valid.
module tb_peripheral_gpio;
    import gpio_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] gpio_in;
    logic [W-1:0] gpio_out;
    logic [W-1:0] gpio_oe;
    logic         irq;

    peripheral_gpio_if bus ();

    peripheral_gpio #(
        .WIDTH (W),
        .DEB_W (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic        rd_seen = 1'b0;
    logic [31:0] sb_exp;
    string       sb_tag;

    logic [4:0] a_dout, a_dir, a_din, a_rise, a_fall, a_pend, a_deb, a_rsvd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Remember which edges carried a read strobe.
    always @(posedge clk) rd_seen <= bus.cs & bus.rd;

    // Pop the expected value once the read data is valid.
    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                sb_tag = tag_q.pop_front();
                sb_exp = exp_q.pop_front();
                check(sb_tag, bus.d_out, sb_exp);
            end
        end
    end

    // All bus tasks start at a negedge and return at the next negedge.
    task automatic bus_cycle(input logic c, input logic r, input logic w, input logic [4:0] a,
                             input logic [31:0] d, input logic [31:0] exp, input string tag);
        bus.cs   = c;
        bus.rd   = r;
        bus.wr   = w;
        bus.addr = a;
        bus.d_in = d;
        if (c && r) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        @(negedge clk);
        bus.cs = 1'b0;
        bus.rd = 1'b0;
        bus.wr = 1'b0;
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
        bus_cycle(1'b1, 1'b0, 1'b1, a, d, 32'd0, "");
    endtask

    task automatic rd_reg(input logic [4:0] a, input logic [31:0] exp, input string tag);
        bus_cycle(1'b1, 1'b1, 1'b0, a, 32'd0, exp, tag);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_dout = reg_offset(REG_DOUT);
        a_dir  = reg_offset(REG_DIR);
        a_din  = reg_offset(REG_DIN);
        a_rise = reg_offset(REG_RISE);
        a_fall = reg_offset(REG_FALL);
        a_pend = reg_offset(REG_PEND);
        a_deb  = reg_offset(REG_DEB);
        a_rsvd = reg_offset(REG_RSVD);

        bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.d_in = '0;
        gpio_in = '0;
        reset   = 1'b1;
        idle(3);
        check("rst_gpio_out", gpio_out, 0);
        check("rst_gpio_oe", gpio_oe, 0);
        check("rst_irq", irq, 0);
        check("rst_d_out", bus.d_out, 0);
        reset = 1'b0;
        idle(1);

        // Dirty every register, then reset mid-debounce with inputs moving.
        wr_reg(a_dout, 32'h77);
        wr_reg(a_dir, 32'hFF);
        wr_reg(a_rise, 32'hFF);
        wr_reg(a_fall, 32'hFF);
        wr_reg(a_deb, 32'd3);
        gpio_in = 8'hFF;
        idle(2);
        reset = 1'b1;
        idle(1);
        gpio_in = '0;
        check("mid_rst_oe", gpio_oe, 0);
        check("mid_rst_out", gpio_out, 0);
        check("mid_rst_irq", irq, 0);
        reset = 1'b0;
        idle(6);
        rd_reg(a_pend, 32'h0, "mid_rst_pend");
        rd_reg(a_deb, 32'h0, "mid_rst_deb");
        rd_reg(a_din, 32'h0, "mid_rst_din");
        check("mid_rst_irq_after", irq, 0);

        // Output path.
        wr_reg(a_dir, 32'hF0);
        wr_reg(a_dout, 32'hA5);
        check("oe_f0", gpio_oe, 8'hF0);
        check("out_a5", gpio_out, 8'hA5);
        rd_reg(a_dout, 32'h0000_00A5, "rd_dout");

        // Bypass latency: new value visible to a read strobed on the third edge.
        gpio_in = 8'h3C;
        rd_reg(a_din, 32'h0, "byp_e0");
        rd_reg(a_din, 32'h0, "byp_e1");
        rd_reg(a_din, 32'h0, "byp_e2");
        rd_reg(a_din, 32'h3C, "byp_e3");
        rd_reg(a_rsvd, 32'h0, "rd_rsvd");
        gpio_in = '0;
        idle(4);

        // Debounce with a period of 4: glitch rejected, held level accepted.
        wr_reg(a_rise, 32'h01);
        wr_reg(a_deb, 32'd4);
        rd_reg(a_deb, 32'd4, "rd_deb");
        gpio_in = 8'h01;
        idle(3);
        gpio_in = '0;
        idle(12);
        rd_reg(a_din, 32'h0, "deb_glitch_din");
        rd_reg(a_pend, 32'h0, "deb_glitch_pend");
        check("deb_glitch_irq", irq, 0);
        gpio_in = 8'h01;
        idle(12);
        rd_reg(a_din, 32'h1, "deb_hold_din");
        rd_reg(a_pend, 32'h1, "deb_hold_pend");
        wr_reg(a_pend, 32'h1);
        gpio_in = '0;
        idle(12);
        wr_reg(a_deb, 32'd0);
        wr_reg(a_rise, 32'd0);

        // Edge detection and interrupt.
        gpio_in = 8'h02;
        idle(5);
        wr_reg(a_rise, 32'h01);
        wr_reg(a_fall, 32'h02);
        rd_reg(a_pend, 32'h0, "edge_init_pend");
        gpio_in = 8'h03;
        idle(4);
        check("irq_rise", irq, 1);
        rd_reg(a_pend, 32'h1, "pend_rise");
        gpio_in = 8'h01;
        idle(4);
        rd_reg(a_pend, 32'h3, "pend_fall");
        wr_reg(a_pend, 32'h1);
        rd_reg(a_pend, 32'h2, "w1c_bit0");
        check("irq_after_w1c0", irq, 1);
        wr_reg(a_pend, 32'h2);
        check("irq_after_w1c1", irq, 0);
        rd_reg(a_pend, 32'h0, "w1c_all");

        // A rising edge and a clear of the same bit in the same cycle: set wins.
        gpio_in = 8'h00;
        idle(4);
        rd_reg(a_pend, 32'h0, "sw_pre");
        gpio_in = 8'h01;
        idle(3);
        wr_reg(a_pend, 32'h1);
        rd_reg(a_pend, 32'h1, "set_wins");
        check("set_wins_irq", irq, 1);
        wr_reg(a_pend, 32'h1);
        rd_reg(a_pend, 32'h0, "set_wins_clr");
        check("set_wins_irq_clr", irq, 0);

        // Bus decode.
        bus_cycle(1'b0, 1'b0, 1'b1, a_dout, 32'hFF, 32'd0, "");
        check("cs0_wr_out", gpio_out, 8'hA5);
        rd_reg(a_dout, 32'hA5, "cs0_wr_rd");
        bus_cycle(1'b1, 1'b1, 1'b1, a_dir, 32'h0F, 32'hF0, "rdwr_old");
        check("rdwr_oe", gpio_oe, 8'h0F);
        rd_reg(a_dir, 32'h0F, "rdwr_new");
        wr_reg(a_rsvd, 32'hFFFF_FFFF);
        rd_reg(a_rsvd, 32'h0, "rsvd_wr");
        wr_reg(a_din, 32'hFF);
        rd_reg(a_din, 32'h01, "din_ro");
        wr_reg(a_dout, 32'hFFFF_FF5A);
        rd_reg(a_dout, 32'h5A, "dout_trunc");
        check("dout_trunc_pin", gpio_out, 8'h5A);
        idle(3);
        check("d_out_hold", bus.d_out, 32'h5A);

        idle(2);
        check("sb_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/peripheral_gpio.md
Name: peripheral_gpio

Overview:
- Memory-mapped GPIO peripheral on the FemtoRV32 SOC bus; occupies the chip-select slot decoded at 0x0041_xxxx.
- The SOC drives it with cs, rd, wr, addr[4:0] and d_in, and muxes d_out back into mem_rdata.
- Provides:
  - per-pin direction and output data,
  - two-flop input synchronisation,
  - tick-based debounce,
  - rising/falling edge detection,
  - sticky write-1-to-clear pending flags with a level interrupt.

Parameters:
- WIDTH, 8, number of GPIO pins (1..32).
- DEB_W, 16, width of the debounce prescaler and DEBOUNCE register.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- d_in  input  32  write data (mem_wdata).
- cs  input  1  chip select from the SOC address decoder.
- addr  input  5  byte offset (mem_addr[4:0]); addr[1:0] ignored.
- rd  input  1  read strobe (mem_rstrb).
- wr  input  1  write strobe (|mem_wmask).
- d_out  output  32  registered read data.
- gpio_in  input  WIDTH  asynchronous pad inputs.
- gpio_out  output  WIDTH  output data to pads.
- gpio_oe  output  WIDTH  output enable per pin (1 = drive).
- irq  output  1  OR of PENDING.

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-high.
- Reset values:
  - All registers 0: DATA_OUT, DIR, RISE_EN, FALL_EN, PENDING, DEBOUNCE, prescaler.
  - Both synchroniser stages, the debounced value and the previous-debounced value are 0.
  - Outputs: d_out=0, gpio_out=0, gpio_oe=0, irq=0.
  - Reset mid-debounce or mid-edge discards all state; no spurious pending flag after release with inputs at 0.
- Register map (addr[4:2]); bits above WIDTH read 0 and are ignored on write:
  - 0 DATA_OUT RW
  - 1 DIR RW (1 = output)
  - 2 DATA_IN RO (debounced value)
  - 3 RISE_EN RW
  - 4 FALL_EN RW
  - 5 PENDING R/W1C
  - 6 DEBOUNCE RW (DEB_W bits)
  - 7 reserved: reads 0, writes ignored.
- Write: takes effect at the posedge where cs & wr; full 32-bit write, no byte lanes. A write to DATA_IN is ignored.
- Read:
  - At the posedge where cs & rd, d_out is loaded with the addressed register. Data is valid the cycle after the strobe (1-cycle latency).
  - d_out holds its value until the next cs & rd.
  - If cs & rd & wr occur in the same cycle, the read returns the pre-write value.
- Output path: gpio_out = DATA_OUT and gpio_oe = DIR, both driven directly from registers with no extra latency.
- Synchroniser: sync = gpio_in through two flops, sampled every cycle.
- Debounce:
  - DEBOUNCE = 0: bypass; debounced <= sync every cycle. Latency from pin to DATA_IN is 3 cycles.
  - DEBOUNCE = N > 0:
    - The prescaler counts 0..N-1 and wraps; a tick fires on the wrap (every N cycles).
    - On each tick, sample <= sync. A pin's debounced bit updates to sync only if sync equals sample (stable across two consecutive ticks).
  - Writing DEBOUNCE clears the prescaler to 0 in the same cycle.
- Edge detect:
  - prev <= debounced every cycle.
  - rise = debounced & ~prev; fall = ~debounced & prev.
- PENDING:
  - next = (PENDING & ~clr) | (rise & RISE_EN) | (fall & FALL_EN), where clr = d_in when PENDING is written, else 0.
  - A new edge and a clear on the same bit in the same cycle: set wins.
  - Clearing RISE_EN or FALL_EN does not clear existing pending bits.
- irq: registered, irq <= |PENDING_next. It asserts 1 cycle after the edge becomes visible in debounced.
- Pins configured as outputs are still sampled; edges on them are detected normally.

Decomposition:
- Shared package gpio_pkg holds:
  - register offset constants: REG_DOUT=0, REG_DIR=1, REG_DIN=2, REG_RISE=3, REG_FALL=4, REG_PEND=5, REG_DEB=6;
  - the default WIDTH and DEB_W.
- One sub-module, gpio_debounce: synchroniser, prescaler, tick sampling and debounced output, parameterised by WIDTH and DEB_W.
- peripheral_gpio keeps the register file, edge/pending logic, read mux and d_out register.

Test Plan:
- Reset and output path: assert reset mid-run, then write DIR=0xF0 and DATA_OUT=0xA5 → gpio_oe=0xF0, gpio_out=0xA5; reading offset 0x00 returns 0x000000A5 on d_out one cycle after rd.
- Bypass input: DEBOUNCE=0, gpio_in 0x00→0x3C → DATA_IN reads 0x3C starting 3 cycles after the change; reading offset 0x1C returns 0.
- Debounce: DEBOUNCE=4, glitch pin0 high for 3 cycles → DATA_IN stays 0, no pending. Hold pin0 high for 12 cycles → DATA_IN bit0=1 within 2 ticks (≤8 cycles after sync).
- Edge and irq: RISE_EN=0x01, FALL_EN=0x02, DEBOUNCE=0; pin0 rises → PENDING=0x01 and irq=1. Pin1 falls → PENDING=0x03. Write PENDING=0x01 → PENDING=0x02, irq stays 1. Write 0x02 → irq=0.
- Set-wins collision: a rising edge on pin0 arrives in the same cycle as a write of PENDING=0x01 → PENDING bit0 remains 1 and irq stays 1.
- Bus decode: cs=0 with wr=1 to DATA_OUT → no change; simultaneous rd & wr to DIR → d_out returns the old DIR, and a subsequent read returns the new DIR.
